endme_mc_core: RTL and testbench
================================

Name: endme_mc_core

Overview:
- Parametrised, multi-cycle successor to the single-cycle EnDMe accumulator processor.
- Fetches 9-bit instructions from an external instruction memory and accesses data memory over req/ack handshakes, sequencing each instruction through an FSM.
- Generalises data width and register count, adds an explicit HALT opcode, and tolerates wait-stated memories.
- Sits between the SoC memory fabric and the test bench `done` monitor.

Parameters:
- DW, 8, accumulator/register/data-memory width; must be >= 8.
- NREG, 16, register-file entries; 2..16. Register index is instr[3:0]; indices >= NREG read 0 and ignore writes.
- IAW, 16, instruction address (PC) width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  IAW  fetch address (the PC).
- imem_ack  in  1  fetch complete; imem_rdata is valid this cycle.
- imem_rdata  in  9  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DW  data address.
- dmem_wdata  out  DW  store data.
- dmem_ack  in  1  access complete; dmem_rdata is valid this cycle for a load.
- dmem_rdata  in  DW  load data.
- done  out  1  core halted.
- illegal  out  1  trap flag for an undefined opcode.

Behaviour:
- Reset (RESET low, asynchronous):
  - FSM goes to FETCH; PC = 0; ACC = 0; all registers = 0.
  - All outputs = 0, except imem_req, which rises on the first clock edge after RESET is released.
  - Reset asserted mid-transaction abandons the transaction; a late ack is ignored.
- Instruction encoding:
  - instr[8] = 1: LDI, ACC = zero-extended instr[7:0].
  - instr[8] = 0: op = instr[7:4], r = instr[3:0].
- Opcodes (R[r] is the selected register):
  - 0 ADD: ACC = ACC + R[r], mod 2^DW.
  - 1 SUB: ACC = ACC - R[r], mod 2^DW.
  - 2 AND, 3 OR, 4 XOR: bitwise ACC op R[r].
  - 5 NOT: ACC = ~ACC.
  - 6 MVA: ACC = R[r].
  - 7 MVR: R[r] = ACC.
  - 8 LD: ACC = mem[R[r]].
  - 9 ST: mem[R[r]] = ACC.
  - A BEQ1: PC = zero-extended R[r] if ACC == 1, else PC + 1.
  - B JMP: PC = zero-extended R[r].
  - F HALT.
  - C, D, E: undefined; behaviour set by the Optional Feature.
- No flags; overflow wraps silently.
- FSM states:
  - FETCH: imem_req = 1, imem_addr = PC. On a cycle with imem_ack = 1, latch imem_rdata and go to EXEC.
  - EXEC (1 cycle): performs ALU/LDI/MVR/branch, updating ACC, registers and PC at the exit edge.
    - LD/ST: go to MEM.
    - HALT: go to HALTED.
    - All others: go to FETCH.
  - MEM: dmem_req = 1, dmem_we = (op == 9), dmem_addr = R[r], dmem_wdata = ACC. On dmem_ack, LD loads ACC = dmem_rdata; PC = PC + 1; go to FETCH.
  - HALTED: done = 1, no requests. Only RESET leaves this state.
- Handshake rules:
  - req and addr/data are held stable until the cycle ack is sampled high.
  - req deasserts in the following cycle.
  - An ack while req is low is ignored.
  - Zero-wait-state ack (same cycle as req) is legal.
- Latency with zero-wait memories: 2 cycles per instruction, 3 for LD/ST.
- PC wraps from 2^IAW - 1 to 0 with no error.
- Combinational paths: none from inputs to outputs; all outputs are registered or decoded from state.

Optional Feature:
- Macro: ENDME_ILLEGAL_TRAP_EN.
- Defined: opcodes C/D/E in EXEC set illegal = 1 and go to HALTED (done = 1). PC is left pointing at the offending instruction. illegal stays high until reset.
- Undefined: C/D/E execute as NOPs (PC + 1); illegal is tied 0.

Test Plan:
- Reset mid-fetch: RESET low while imem_req = 1 and ack withheld. Required: imem_req drops immediately, all outputs 0. After release, the first fetch is at imem_addr = 0.
- Arithmetic: program 1_05, 0_71, 1_03, 0_01, 0_F0 with zero-wait memory. Required: r1 = 5, ACC = 8, done = 1 after exactly 10 cycles; imem_req low thereafter.
- Wait states: imem_ack delayed 3 cycles on the second fetch. Required: imem_req and imem_addr = 1 held for 4 cycles; retired results identical to the zero-wait run.
- Load/store: program LDI 0x20, MVR r2, LDI 0xAA, ST r2. Required: dmem_req = 1, dmem_we = 1, dmem_addr = 0x20, dmem_wdata = 0xAA. Then LDI 0, LD r2 with dmem_rdata = 0xAA gives ACC = 0xAA.
- Branches: r3 = 0x10, ACC = 1, BEQ1 r3 gives next imem_addr = 0x10. With ACC = 2 it gives PC + 1. JMP r3 gives 0x10 unconditionally.
- Illegal opcode 0_C0 at address 4:
  - With ENDME_ILLEGAL_TRAP_EN: illegal = 1, done = 1, no further fetch.
  - Without: next fetch at 5, illegal = 0.

Source files
------------

// File: rtl/endme_mc_core.sv
// endme_mc_core: multi-cycle EnDMe accumulator core with req/ack instruction and data ports.
// Build option: define ENDME_ILLEGAL_TRAP_EN to trap opcodes C/D/E (illegal=1, halt); otherwise they are NOPs.
`timescale 1ns/1ps
module endme_mc_core #(
  parameter int DW   = 8,
  parameter int NREG = 16,
  parameter int IAW  = 16
) (
  input  logic           CLK,
  input  logic           RESET,
  output logic           imem_req,
  output logic [IAW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [8:0]     imem_rdata,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_ack,
  input  logic [DW-1:0]  dmem_rdata,
  output logic           done,
  output logic           illegal
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_MEM    = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_MVA  = 4'h6;
  localparam logic [3:0] OP_MVR  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQ1 = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [4:0] NREG_L = 5'(NREG);

  logic [1:0]     state;
  logic           running;
  logic [IAW-1:0] pc;
  logic [DW-1:0]  acc;
  logic [8:0]     instr;
  logic [DW-1:0]  regs [0:15];

  logic           is_ldi;
  logic [3:0]     op;
  logic [3:0]     ridx;
  logic           reg_valid;
  logic [DW-1:0]  rval;
  logic [DW-1:0]  ldi_val;
  logic [IAW-1:0] rval_pc;

  logic [DW-1:0]  exec_acc;
  logic [IAW-1:0] exec_pc;
  logic [1:0]     exec_state;
  logic           exec_reg_we;

  assign is_ldi    = instr[8];
  assign op        = instr[7:4];
  assign ridx      = instr[3:0];
  assign reg_valid = ({1'b0, ridx} < NREG_L);
  // Entries at or above NREG are never written, so they always read back as zero.
  assign rval      = regs[ridx];

  if (DW > 8) begin : g_ldi_ext
    assign ldi_val = {{(DW-8){1'b0}}, instr[7:0]};
  end else begin : g_ldi_direct
    assign ldi_val = instr[7:0];
  end

  if (IAW > DW) begin : g_pc_ext
    assign rval_pc = {{(IAW-DW){1'b0}}, rval};
  end else if (IAW == DW) begin : g_pc_direct
    assign rval_pc = rval;
  end else begin : g_pc_trunc
    assign rval_pc = rval[IAW-1:0];
  end

  always_comb begin
    exec_acc    = acc;
    exec_pc     = pc + IAW'(1);
    exec_state  = S_FETCH;
    exec_reg_we = 1'b0;
    if (is_ldi) begin
      exec_acc = ldi_val;
    end else begin
      case (op)
        OP_ADD:  exec_acc = acc + rval;
        OP_SUB:  exec_acc = acc - rval;
        OP_AND:  exec_acc = acc & rval;
        OP_OR:   exec_acc = acc | rval;
        OP_XOR:  exec_acc = acc ^ rval;
        OP_NOT:  exec_acc = ~acc;
        OP_MVA:  exec_acc = rval;
        OP_MVR:  exec_reg_we = 1'b1;
        // Memory ops advance the PC only once the data access completes.
        OP_LD, OP_ST: begin
          exec_pc    = pc;
          exec_state = S_MEM;
        end
        OP_BEQ1: if (acc == DW'(1)) exec_pc = rval_pc;
        OP_JMP:  exec_pc = rval_pc;
        OP_HALT: begin
          exec_pc    = pc;
          exec_state = S_HALTED;
        end
`ifdef ENDME_ILLEGAL_TRAP_EN
        default: begin
          exec_pc    = pc;
          exec_state = S_HALTED;
        end
`else
        default: ;
`endif
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_FETCH;
      running <= 1'b0;
      pc      <= '0;
      acc     <= '0;
      instr   <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      running <= 1'b1;
      case (state)
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            instr <= imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc   <= exec_acc;
          pc    <= exec_pc;
          state <= exec_state;
          if (exec_reg_we && reg_valid) regs[ridx] <= acc;
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (op == OP_LD) acc <= dmem_rdata;
            pc    <= pc + IAW'(1);
            state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENDME_ILLEGAL_TRAP_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      illegal <= 1'b0;
    end else if (state == S_EXEC && !is_ldi && op >= 4'hC && op <= 4'hE) begin
      illegal <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
`endif

  // The running flag holds off the first fetch request until the first edge after reset release.
  assign imem_req   = running && (state == S_FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = dmem_req && (op == OP_ST);
  assign dmem_addr  = dmem_req ? rval : '0;
  assign dmem_wdata = dmem_req ? acc : '0;
  assign done       = (state == S_HALTED);

endmodule

// File: tb/tb_endme_mc_core.sv
// tb_endme_mc_core: directed programs against an instruction-level model of the EnDMe core.
// Honours ENDME_ILLEGAL_TRAP_EN in the same way as the design for the illegal-opcode program.
`timescale 1ns/1ps
module tb_endme_mc_core;
  localparam int DW  = 8;
  localparam int IAW = 16;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           imem_req;
  logic [IAW-1:0] imem_addr;
  logic           imem_ack;
  logic [8:0]     imem_rdata;
  logic           dmem_req;
  logic           dmem_we;
  logic [DW-1:0]  dmem_addr;
  logic [DW-1:0]  dmem_wdata;
  logic           dmem_ack;
  logic [DW-1:0]  dmem_rdata;
  logic           done;
  logic           illegal;

  endme_mc_core #(.DW(DW), .NREG(16), .IAW(IAW)) dut (
    .CLK(CLK), .RESET(RESET),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .done(done), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;

  logic [8:0] imem [0:255];
  logic [7:0] dmem [0:255];

  int wait_at, wait_n, iwait_cnt, fetch_idx, hold_cnt;
  int cyc = 0, first_req_cyc, done_cyc, ld_cnt;
  bit stray_ack;
  logic [IAW-1:0] fetch_log [$];
  logic [7:0] st_addr_log [$];
  logic [7:0] st_data_log [$];
  logic [8:0] prog [$];

  logic [IAW-1:0] m_pc;
  logic [7:0] m_acc, m_mem_addr;
  logic [7:0] m_r [0:15];
  bit m_halted, m_illegal, m_pending, m_mem_we;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_acc = '0; m_halted = 0; m_illegal = 0; m_pending = 0; m_mem_we = 0; m_mem_addr = '0;
    for (int i = 0; i < 16; i++) m_r[i] = '0;
  endtask

  task automatic clear_run();
    iwait_cnt = 0; fetch_idx = 0; hold_cnt = 0; first_req_cyc = -1; done_cyc = -1; ld_cnt = 0;
    fetch_log.delete(); st_addr_log.delete(); st_data_log.delete();
    model_reset();
  endtask

  // Instruction-set semantics: one call per accepted fetch.
  task automatic model_fetch(input logic [IAW-1:0] addr, input logic [8:0] w);
    logic [3:0] op, r;
    logic [7:0] rv;
    logic [IAW-1:0] nxt;
    checkOutput("fetch_addr", 32'(addr), 32'(m_pc));
    checkOutput("fetch_while_busy", 32'({m_halted, m_pending}), 32'd0);
    fetch_log.push_back(addr);
    op = w[7:4]; r = w[3:0]; rv = m_r[r];
    nxt = m_pc + 1;
    if (w[8]) m_acc = w[7:0];
    else begin
      case (op)
        4'h0: m_acc = m_acc + rv;
        4'h1: m_acc = m_acc - rv;
        4'h2: m_acc = m_acc & rv;
        4'h3: m_acc = m_acc | rv;
        4'h4: m_acc = m_acc ^ rv;
        4'h5: m_acc = ~m_acc;
        4'h6: m_acc = rv;
        4'h7: m_r[r] = m_acc;
        4'h8, 4'h9: begin m_pending = 1; m_mem_we = (op == 4'h9); m_mem_addr = rv; nxt = m_pc; end
        4'hA: if (m_acc == 8'd1) nxt = IAW'(rv);
        4'hB: nxt = IAW'(rv);
        4'hF: begin m_halted = 1; nxt = m_pc; end
        default: begin
`ifdef ENDME_ILLEGAL_TRAP_EN
          m_halted = 1; m_illegal = 1; nxt = m_pc;
`endif
        end
      endcase
    end
    m_pc = nxt;
  endtask

  task automatic model_mem(input logic we, input logic [7:0] a, input logic [7:0] wd, input logic [7:0] rd);
    checkOutput("dmem_expected", 32'(m_pending), 32'd1);
    checkOutput("dmem_we", 32'(we), 32'(m_mem_we));
    checkOutput("dmem_addr", 32'(a), 32'(m_mem_addr));
    if (we) checkOutput("dmem_wdata", 32'(wd), 32'(m_acc));
    else begin m_acc = rd; ld_cnt++; end
    m_pending = 0;
    m_pc = m_pc + 1;
  endtask

  // Memory responders plus the per-cycle compare against the model, all away from the rising edge.
  always @(negedge CLK) begin
    cyc++;
    if (imem_req) begin
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (fetch_idx == wait_at && imem_addr == IAW'(1)) hold_cnt++;
      if (iwait_cnt >= ((fetch_idx == wait_at) ? wait_n : 0)) begin
        imem_ack = 1'b1; imem_rdata = imem[imem_addr[7:0]]; iwait_cnt = 0;
      end else begin
        imem_ack = 1'b0; iwait_cnt++;
      end
    end else begin
      imem_ack = stray_ack; imem_rdata = 9'h0F0;
    end
    if (imem_req && imem_ack) begin
      model_fetch(imem_addr, imem_rdata);
      fetch_idx++;
    end
    if (dmem_req) begin
      dmem_ack = 1'b1;
      dmem_rdata = dmem_we ? 8'h00 : dmem[dmem_addr];
      model_mem(dmem_we, dmem_addr, dmem_wdata, dmem_rdata);
      if (dmem_we) begin
        dmem[dmem_addr] = dmem_wdata;
        st_addr_log.push_back(dmem_addr);
        st_data_log.push_back(dmem_wdata);
      end
    end else begin
      dmem_ack = 1'b0;
    end
    if (RESET) begin
      checkOutput("done_implies_halt", 32'(done && !m_halted), 32'd0);
      if (done) checkOutput("illegal_vs_model", 32'(illegal), 32'(m_illegal));
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic load_prog(input int base);
    for (int i = 0; i < prog.size(); i++) imem[base + i] = prog[i];
  endtask

  task automatic applyStimulus(input int w_at, input int w_n);
    @(negedge CLK); #2;
    RESET = 1'b0;
    wait_at = w_at; wait_n = w_n;
    clear_run();
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b1;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge CLK); n++; end
    #1;
    checkOutput("done_reached", 32'(done), 32'd1);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 9'h0F0;
  endtask

  logic [7:0] alu_exp [10] = '{8'hE1, 8'hA5, 8'h24, 8'h3C, 8'h00, 8'hFF, 8'hC3, 8'hC8, 8'h40, 8'h2C};

  initial begin
    RESET = 1'b0; stray_ack = 0; imem_ack = 0; imem_rdata = '0; dmem_ack = 0; dmem_rdata = '0;
    wait_at = -1; wait_n = 0;
    clear_run();
    for (int i = 0; i < 256; i++) dmem[i] = ~8'(i);
    clear_imem();
    prog = '{9'h105, 9'h071, 9'h103, 9'h001, 9'h0F0};
    load_prog(0);
    repeat (3) @(negedge CLK); #1;
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);

    $display("[TB] reset during a withheld fetch");
    applyStimulus(0, 100000);
    #1 checkOutput("rel_req_before_edge", 32'(imem_req), 32'd0);
    repeat (3) @(negedge CLK); #1;
    checkOutput("midfetch_req", 32'(imem_req), 32'd1);
    checkOutput("midfetch_addr", 32'(imem_addr), 32'd0);
    #1 RESET = 1'b0; stray_ack = 1; wait_at = -1;
    #1;
    checkOutput("midrst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("midrst_outputs", 32'({dmem_req, dmem_we, done, illegal}), 32'd0);
    clear_run();
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b1;
    run_until_done(200);
    stray_ack = 0;
    checkOutput("midrst_first_fetch", 32'(fetch_log[0]), 32'd0);
    checkOutput("midrst_fetches", 32'(fetch_log.size()), 32'd5);

    $display("[TB] arithmetic, zero wait");
    applyStimulus(-1, 0);
    run_until_done(200);
    checkOutput("arith_cycles", 32'(done_cyc - first_req_cyc), 32'd10);
    checkOutput("arith_model_r1", 32'(m_r[1]), 32'd5);
    checkOutput("arith_model_acc", 32'(m_acc), 32'd8);
    repeat (5) @(negedge CLK); #1;
    checkOutput("arith_req_after_halt", 32'(imem_req), 32'd0);
    checkOutput("arith_fetches", 32'(fetch_log.size()), 32'd5);

    $display("[TB] arithmetic, 3 wait states on second fetch");
    applyStimulus(1, 3);
    run_until_done(200);
    checkOutput("wait_hold_cycles", 32'(hold_cnt), 32'd4);
    checkOutput("wait_cycles", 32'(done_cyc - first_req_cyc), 32'd13);
    checkOutput("wait_model_acc", 32'(m_acc), 32'd8);
    checkOutput("wait_fetches", 32'(fetch_log.size()), 32'd5);

    $display("[TB] load/store");
    clear_imem();
    prog = '{9'h120, 9'h072, 9'h121, 9'h073, 9'h1AA, 9'h092, 9'h100, 9'h082, 9'h093, 9'h0F0};
    load_prog(0);
    applyStimulus(-1, 0);
    run_until_done(200);
    checkOutput("ls_stores", 32'(st_data_log.size()), 32'd2);
    checkOutput("ls_st_addr", 32'(st_addr_log[0]), 32'h20);
    checkOutput("ls_st_data", 32'(st_data_log[0]), 32'hAA);
    checkOutput("ls_loads", 32'(ld_cnt), 32'd1);
    checkOutput("ls_loaded_acc_stored", 32'(st_data_log[1]), 32'hAA);
    checkOutput("ls_mem21", 32'(dmem[8'h21]), 32'hAA);

    $display("[TB] ALU operations");
    clear_imem();
    prog = '{9'h140, 9'h076, 9'h13C, 9'h071, 9'h1A5, 9'h001, 9'h096, 9'h011, 9'h096, 9'h021,
             9'h096, 9'h031, 9'h096, 9'h041, 9'h096, 9'h050, 9'h096, 9'h011, 9'h096, 9'h104,
             9'h011, 9'h096, 9'h066, 9'h096, 9'h1F0, 9'h001, 9'h096, 9'h0F0};
    load_prog(0);
    applyStimulus(-1, 0);
    run_until_done(400);
    checkOutput("alu_stores", 32'(st_data_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < st_data_log.size(); i++)
      checkOutput($sformatf("alu_result_%0d", i), 32'(st_data_log[i]), 32'(alu_exp[i]));

    $display("[TB] branches");
    clear_imem();
    prog = '{9'h110, 9'h073, 9'h130, 9'h075, 9'h102, 9'h0A3, 9'h0B3};
    load_prog(0);
    prog = '{9'h0A5, 9'h101, 9'h0A3};
    load_prog(16);
    applyStimulus(-1, 0);
    run_until_done(200);
    checkOutput("br_fetches", 32'(fetch_log.size()), 32'd12);
    if (fetch_log.size() == 12) begin
      checkOutput("br_beq_not_taken", 32'(fetch_log[6]), 32'h06);
      checkOutput("br_jmp", 32'(fetch_log[7]), 32'h10);
      checkOutput("br_beq_taken", 32'(fetch_log[10]), 32'h10);
      checkOutput("br_final", 32'(fetch_log[11]), 32'h30);
    end

    $display("[TB] undefined opcode");
    clear_imem();
    prog = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h0C0, 9'h0F0};
    load_prog(0);
    applyStimulus(-1, 0);
    run_until_done(200);
    repeat (4) @(negedge CLK); #1;
`ifdef ENDME_ILLEGAL_TRAP_EN
    checkOutput("ill_fetches", 32'(fetch_log.size()), 32'd5);
    checkOutput("ill_flag", 32'(illegal), 32'd1);
`else
    checkOutput("ill_fetches", 32'(fetch_log.size()), 32'd6);
    checkOutput("ill_next_fetch", 32'(fetch_log[fetch_log.size()-1]), 32'd5);
    checkOutput("ill_flag", 32'(illegal), 32'd0);
`endif
    checkOutput("ill_req_after", 32'(imem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
